// File: rtl/cyclic_shift_reg_ctrl.sv
// Job sequencer for a cyclic shift register: latches a descriptor, streams in the fill writes,
// then issues rotate-reads through a valid/ready port for the programmed number of rotations.
module cyclic_shift_reg_ctrl #(
  parameter int unsigned R_DEPTH      = 24,
  parameter int unsigned R_DATA_WIDTH = 16,
  parameter int unsigned W_DATA_WIDTH = 192,
  parameter int unsigned REPEAT_WIDTH = 8,
  localparam int unsigned RATIO        = W_DATA_WIDTH / R_DATA_WIDTH,
  localparam int unsigned W_DEPTH      = R_DEPTH / RATIO,
  localparam int unsigned W_ADDR_WIDTH = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1,
  localparam int unsigned R_ADDR_WIDTH = (R_DEPTH > 1) ? $clog2(R_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [W_ADDR_WIDTH-1:0] cfg_w_addr_max,
  input  logic [R_ADDR_WIDTH-1:0] cfg_r_addr_max,
  input  logic [REPEAT_WIDTH-1:0] cfg_repeats,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    m_rot_last,
  output logic                    w_en,
  output logic                    r_en,
  output logic [W_ADDR_WIDTH-1:0] w_addr_max,
  output logic [R_ADDR_WIDTH-1:0] r_addr_max,
  output logic                    busy
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain
  } state_e;

  state_e                  state_q;
  logic [W_ADDR_WIDTH-1:0] w_cnt_q;
  logic [R_ADDR_WIDTH-1:0] r_cnt_q;
  logic [REPEAT_WIDTH-1:0] rep_cnt_q;
  logic [W_ADDR_WIDTH-1:0] w_addr_max_q;
  logic [R_ADDR_WIDTH-1:0] r_addr_max_q;
  logic [REPEAT_WIDTH-1:0] repeats_q;

  logic in_fill;
  logic in_drain;
  logic fill_done;
  logic rot_wrap;
  logic job_done;

  // All handshake outputs are gated by reset so they read 0 during a mid-job reset cycle.
  assign in_fill  = (state_q == StFill) && !reset;
  assign in_drain = (state_q == StDrain) && !reset;

  assign cfg_ready = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle) && !reset;

  assign s_ready = in_fill && clken;
  assign w_en    = s_valid && s_ready;

  assign m_valid = in_drain;
  assign r_en    = m_valid && m_ready && clken;

  assign fill_done  = (w_cnt_q == w_addr_max_q);
  assign rot_wrap   = (r_cnt_q == r_addr_max_q);
  assign job_done   = (rep_cnt_q == repeats_q);
  assign m_rot_last = m_valid && rot_wrap;
  assign m_last     = m_rot_last && job_done;

  assign w_addr_max = w_addr_max_q;
  assign r_addr_max = r_addr_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      w_cnt_q      <= '0;
      r_cnt_q      <= '0;
      rep_cnt_q    <= '0;
      w_addr_max_q <= '0;
      r_addr_max_q <= '0;
      repeats_q    <= '0;
    end else if (clken) begin
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            w_addr_max_q <= cfg_w_addr_max;
            r_addr_max_q <= cfg_r_addr_max;
            repeats_q    <= cfg_repeats;
            w_cnt_q      <= '0;
            r_cnt_q      <= '0;
            rep_cnt_q    <= '0;
            state_q      <= StFill;
          end
        end
        StFill: begin
          if (w_en) begin
            if (fill_done) begin
              // Ending at 0 keeps the shift register's own write pointer aligned for the next job.
              w_cnt_q <= '0;
              state_q <= StDrain;
            end else begin
              w_cnt_q <= w_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (r_en) begin
            if (rot_wrap) begin
              r_cnt_q <= '0;
              if (job_done) begin
                rep_cnt_q <= '0;
                state_q   <= StIdle;
              end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
              end
            end else begin
              r_cnt_q <= r_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cyclic_shift_reg_ctrl.sv
// Directed bench for cyclic_shift_reg_ctrl: table of job descriptors with hand-computed
// write/read/flag counts, plus hand-written clken, reset and busy-descriptor sequences.
module tb_cyclic_shift_reg_ctrl;

  logic       clk;
  logic       reset;
  logic       clken;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_w_addr_max;
  logic [4:0] cfg_r_addr_max;
  logic [7:0] cfg_repeats;
  logic       s_valid;
  logic       s_ready;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       m_rot_last;
  logic       w_en;
  logic       r_en;
  logic [0:0] w_addr_max;
  logic [4:0] r_addr_max;
  logic       busy;

  cyclic_shift_reg_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .clken         (clken),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_w_addr_max(cfg_w_addr_max),
    .cfg_r_addr_max(cfg_r_addr_max),
    .cfg_repeats   (cfg_repeats),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .m_rot_last    (m_rot_last),
    .w_en          (w_en),
    .r_en          (r_en),
    .w_addr_max    (w_addr_max),
    .r_addr_max    (r_addr_max),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge; inputs set here are seen by the next rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int wmax;
    int rmax;
    int reps;
    bit gaps;
    bit bp;
    int exp_wr;
    int exp_rd;
    int exp_rot;
    int exp_first;
    int exp_last;
    int exp_cyc;
  } vec_t;

  vec_t vecs[6];

  int n_wr, n_rd, n_rot, first_rot, last_pos, n_last, n_overlap, n_badhs, n_cyc;
  int sready_first, idle_ready, idle_busy;

  // Caller must be just after a falling edge; returns just after the falling edge of cycle K+1.
  task automatic run_job(input int wmax, input int rmax, input int reps, input bit gaps,
                         input bit bp);
    int guard;
    n_wr = 0; n_rd = 0; n_rot = 0; first_rot = 0; last_pos = 0; n_last = 0;
    n_overlap = 0; n_badhs = 0; n_cyc = 0; sready_first = 0;
    cfg_w_addr_max = 1'(wmax);
    cfg_r_addr_max = 5'(rmax);
    cfg_repeats    = 8'(reps);
    cfg_valid      = 1'b1;
    s_valid        = 1'b0;
    m_ready        = 1'b0;
    #1;
    guard = 0;
    while (!cfg_ready && guard < 50) begin
      step();
      guard++;
    end
    @(posedge clk);
    n_cyc = 1;
    for (int c = 0; c < 2000 && n_last == 0; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      s_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_ready   = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (c == 0) sready_first = int'(s_ready);
      if (w_en && r_en) n_overlap++;
      if (w_en && !(s_valid && s_ready)) n_badhs++;
      if (r_en && !(m_valid && m_ready)) n_badhs++;
      if (w_en) n_wr++;
      if (r_en) begin
        n_rd++;
        if (m_rot_last) begin
          n_rot++;
          if (first_rot == 0) first_rot = n_rd;
        end
        if (m_last) begin
          n_last++;
          last_pos = n_rd;
        end
      end
      n_cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    idle_ready = int'(cfg_ready);
    idle_busy  = int'(busy);
  endtask

  task automatic drain_count(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      m_ready = 1'b1;
      #1;
      if (r_en) n++;
      if (r_en && m_last) done = 1'b1;
      step();
    end
    m_ready = 1'b0;
  endtask

  int n;

  initial begin
    vecs[0] = '{1, 23, 1, 1'b0, 1'b0, 2, 48, 2, 24, 48, 51};
    vecs[1] = '{0, 11, 0, 1'b0, 1'b0, 1, 12, 1, 12, 12, 14};
    vecs[2] = '{0, 11, 0, 1'b0, 1'b0, 1, 12, 1, 12, 12, 14};
    vecs[3] = '{1, 23, 1, 1'b1, 1'b1, 2, 48, 2, 24, 48, 51};
    vecs[4] = '{1, 7, 3, 1'b0, 1'b0, 2, 32, 4, 8, 32, 35};
    vecs[5] = '{0, 0, 2, 1'b0, 1'b0, 1, 3, 3, 1, 3, 5};

    reset = 1'b1; clken = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    cfg_w_addr_max = '0; cfg_r_addr_max = '0; cfg_repeats = '0;

    // Reset state
    step();
    step();
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_w_en_r_en", int'({w_en, r_en, m_last, m_rot_last}), 0);
    chk("rst_latches", int'({w_addr_max, r_addr_max}), 0);
    reset = 1'b0;
    #1;
    chk("rel_cfg_ready", int'(cfg_ready), 1);

    // Table-driven jobs, back to back
    foreach (vecs[i]) begin
      run_job(vecs[i].wmax, vecs[i].rmax, vecs[i].reps, vecs[i].gaps, vecs[i].bp);
      chk($sformatf("v%0d_done", i), n_last, 1);
      chk($sformatf("v%0d_writes", i), n_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d_reads", i), n_rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_rot_cnt", i), n_rot, vecs[i].exp_rot);
      chk($sformatf("v%0d_first_rot", i), first_rot, vecs[i].exp_first);
      chk($sformatf("v%0d_last_pos", i), last_pos, vecs[i].exp_last);
      chk($sformatf("v%0d_overlap", i), n_overlap, 0);
      chk($sformatf("v%0d_handshake", i), n_badhs, 0);
      chk($sformatf("v%0d_idle_ready", i), idle_ready, 1);
      chk($sformatf("v%0d_idle_busy", i), idle_busy, 0);
      chk($sformatf("v%0d_w_max", i), int'(w_addr_max), vecs[i].wmax);
      chk($sformatf("v%0d_r_max", i), int'(r_addr_max), vecs[i].rmax);
      if (vecs[i].gaps || vecs[i].bp) begin
        chk($sformatf("v%0d_cycles_min", i), int'(n_cyc >= vecs[i].exp_cyc), 1);
      end else begin
        chk($sformatf("v%0d_sready_n1", i), sready_first, 1);
        chk($sformatf("v%0d_cycles", i), n_cyc, vecs[i].exp_cyc);
      end
    end

    // clken low for 3 cycles mid-FILL and mid-DRAIN: w=1, r=5, rep=0
    cfg_w_addr_max = 1'b1; cfg_r_addr_max = 5'd5; cfg_repeats = 8'd0; cfg_valid = 1'b1;
    #1;
    chk("ck_cfg_ready", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0; s_valid = 1'b1;
    #1;
    chk("ck_w_en_first", int'(w_en), 1);
    step();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ck_fill_hold", int'({s_ready, w_en, busy}), 1);
      step();
    end
    clken = 1'b1;
    #1;
    chk("ck_w_en_second", int'({w_en, m_valid}), 2);
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    chk("ck_m_valid", int'({m_valid, r_en}), 3);
    step();
    step();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ck_drain_hold", int'({m_valid, r_en, m_rot_last, busy}), 9);
      step();
    end
    clken = 1'b1;
    drain_count(n);
    chk("ck_rest_reads", n, 4);
    chk("ck_after_ready", int'(cfg_ready), 1);

    // Reset at read 10 of DRAIN
    cfg_w_addr_max = 1'b1; cfg_r_addr_max = 5'd23; cfg_repeats = 8'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; s_valid = 1'b1;
    step();
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    #1;
    chk("mr_outputs_zero", int'({m_valid, r_en, m_last, m_rot_last, s_ready, w_en, busy}), 0);
    chk("mr_cfg_ready", int'(cfg_ready), 0);
    step();
    reset = 1'b0; m_ready = 1'b0;
    #1;
    chk("mr_rel_state", int'({busy, m_valid, cfg_ready}), 1);
    chk("mr_latches", int'({w_addr_max, r_addr_max}), 0);
    run_job(0, 11, 0, 1'b0, 1'b0);
    chk("mr_job_writes", n_wr, 1);
    chk("mr_job_reads", n_rd, 12);
    chk("mr_job_last", last_pos, 12);

    // cfg_valid held during FILL and DRAIN is ignored until IDLE
    cfg_w_addr_max = 1'b1; cfg_r_addr_max = 5'd3; cfg_repeats = 8'd0; cfg_valid = 1'b1;
    step();
    cfg_w_addr_max = 1'b0; cfg_r_addr_max = 5'd9; s_valid = 1'b1;
    #1;
    chk("cv_fill_ready", int'(cfg_ready), 0);
    step();
    chk("cv_fill_latch", int'({w_addr_max, r_addr_max}), 35);
    step();
    s_valid = 1'b0;
    #1;
    chk("cv_drain_ready", int'({cfg_ready, m_valid}), 1);
    drain_count(n);
    chk("cv_reads", n, 4);
    chk("cv_latch_kept", int'({w_addr_max, r_addr_max}), 35);
    chk("cv_idle_ready", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0; s_valid = 1'b1;
    #1;
    chk("cv_new_latch", int'({busy, w_addr_max, r_addr_max}), 73);
    chk("cv_new_write", int'(w_en), 1);
    step();
    s_valid = 1'b0;
    drain_count(n);
    chk("cv_new_reads", n, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cyclic_shift_reg_ctrl.md
# cyclic_shift_reg_ctrl

Sequencing controller for one `cyclic_shift_reg` instance.
- Accepts a job descriptor: write depth, rotation length and repeat count.
- Fills the register from a wide input stream, then issues rotate-reads through a valid/ready output handshake for the programmed number of repeats.
- Returns to idle for the next job.
- Sits between the weight/pixel feeder and the shift register; drives its `w_en`, `r_en`, `w_addr_max` and `r_addr_max`.

## Interface
Parameters:
- `R_DEPTH`, 24: shift register depth in read words.
- `R_DATA_WIDTH`, 16: read word width.
- `W_DATA_WIDTH`, 192: write word width. Derived values:
  - RATIO = W_DATA_WIDTH/R_DATA_WIDTH
  - W_DEPTH = R_DEPTH/RATIO
  - W_ADDR_WIDTH = $clog2(W_DEPTH)
  - R_ADDR_WIDTH = $clog2(R_DEPTH)
- `REPEAT_WIDTH`, 8: width of repeat count.

Ports:
- `clk` in 1: single clock; one clock domain.
- `reset` in 1: reset is synchronous and active-high.
- `clken` in 1: global clock enable; low freezes all state.
- `cfg_valid` in 1: job descriptor valid.
- `cfg_ready` out 1: high only in IDLE, and 0 while `reset` is high.
- `cfg_w_addr_max` in W_ADDR_WIDTH: last write address (writes per fill = value+1).
- `cfg_r_addr_max` in R_ADDR_WIDTH: last read address (reads per rotation = value+1).
- `cfg_repeats` in REPEAT_WIDTH: extra rotations (total rotations = value+1).
- `s_valid` in 1: input wide word available (data goes straight to the shift register).
- `s_ready` out 1: controller accepts a write.
- `m_valid` out 1: shift register output word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_last` out 1: final read of the final rotation.
- `m_rot_last` out 1: final read of each rotation.
- `w_en` out 1: shift register write enable.
- `r_en` out 1: shift register read/rotate enable.
- `w_addr_max` out W_ADDR_WIDTH: latched `cfg_w_addr_max`.
- `r_addr_max` out R_ADDR_WIDTH: latched `cfg_r_addr_max`.
- `busy` out 1: state ≠ IDLE.

## Operation
States:
- IDLE → FILL on `cfg_valid && cfg_ready && clken`. Latch `w_addr_max`, `r_addr_max` and `cfg_repeats`; clear all counters.
- FILL:
  - `s_ready` = clken.
  - `w_en` = s_valid && s_ready.
  - `w_cnt` increments per write.
  - On the write with `w_cnt == w_addr_max`, go to DRAIN.
- DRAIN:
  - `m_valid` = 1.
  - `r_en` = m_valid && m_ready && clken.
  - `r_cnt` increments per read and wraps to 0 after `r_addr_max`. The wrap asserts `m_rot_last` and increments `rep_cnt`.
  - `m_last` = m_rot_last && (rep_cnt == latched repeats).
  - On the read with `m_last`, go to IDLE.

Rules:
- `w_en` and `r_en` are never high in the same cycle; writes and rotations are mutually exclusive.
- Exactly w_addr_max+1 writes per job. The shift register's internal write pointer therefore ends every job at 0 and stays in step without a shared counter.
- A full rotation of r_addr_max+1 reads restores the original word order. Each repeat therefore replays the same sequence.
- Software guarantees r_addr_max+1 ≤ (w_addr_max+1)·RATIO. The controller does not check this.
- `cfg_valid` outside IDLE is ignored; the descriptor is not consumed.
- `w_addr_max` and `r_addr_max` stay stable from latch until the next accepted descriptor.
- `clken` low: no state, counter or latch update. `s_ready`, `w_en` and `r_en` are forced 0; `m_valid` holds its state value.
- Reset (any state, mid-job included):
  - state IDLE, all counters 0, latches 0.
  - `s_ready`, `m_valid`, `m_last`, `m_rot_last`, `w_en`, `r_en`, `busy` are 0.
  - `cfg_ready` is 0 while reset is high and 1 in the first cycle after reset is released.
  - The shift register is reset from the same source (inverted at top level), so the pointers stay in step.

## Timing
- Descriptor accepted at edge N: `s_ready` is high in cycle N+1.
- Zero-bubble fill: last write at edge M; `m_valid` is high in cycle M+1 and the output word (register 0) is valid then.
- DRAIN sustains one read per cycle with `m_ready` held high.
- After the `m_last` handshake at edge K: `cfg_ready` is high in cycle K+1.
- Minimum job length = 1 + (w_addr_max+1) + (r_addr_max+1)(repeats+1) cycles.
- Back-to-back jobs: one IDLE cycle between jobs.
- `w_en`, `r_en`, `s_ready`, `m_valid`, `m_last`, `m_rot_last` are combinational from state, counters and handshake inputs. All other state is registered.

## Test plan
- Defaults, cfg (w_addr_max=1, r_addr_max=23, repeats=1), input words with elements 0..23:
  - 2 writes, then 48 reads outputting 0..23 twice.
  - `m_rot_last` on reads 24 and 48; `m_last` only on 48.
  - `cfg_ready` high one cycle later.
- cfg (w_addr_max=0, r_addr_max=11, repeats=0):
  - 1 write, 12 reads outputting 0..11, `m_last` on the 12th.
  - Second job immediately after repeats the same order.
- Random `s_valid` gaps and random `m_ready` backpressure on the first config:
  - identical output sequence and counts.
  - `w_en` / `r_en` only asserted on handshake cycles, never together.
- `clken` low for 3 cycles mid-FILL and mid-DRAIN:
  - no counter or state advance during the gap.
  - output sequence unchanged.
- Reset asserted at read 10 of DRAIN:
  - all outputs 0 the next cycle, `cfg_ready`=1 after release.
  - new job runs correctly from write address 0.
- `cfg_valid` pulsed during FILL and DRAIN:
  - ignored, latched maxima unchanged.
  - descriptor accepted only once IDLE is reached.
